// File: rtl/pid_pkg.sv
// Shared FSM encoding and derived-width helpers for the sequential PID controller.
package pid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL_P,
      MUL_I,
      MUL_D,
      SUM,
      OUT
   } state_t;

   // Signed error: one extra bit over the unsigned sample width.
   function automatic int err_w(input int data_w);
      return data_w + 1;
   endfunction

   // Error difference e - e_prev needs one more bit than the error itself.
   function automatic int diff_w(input int data_w);
      return data_w + 2;
   endfunction

   // Headroom for p + acc + d without overflow.
   function automatic int sum_w(input int acc_w);
      return acc_w + 2;
   endfunction

endpackage

// File: rtl/pid_sat.sv
// Generic saturator: clamps a signed value into a signed or unsigned OUT_W-bit range.
// Combinational, no handshake.
module pid_sat #(
   parameter int IN_W       = 22,
   parameter int OUT_W      = 8,
   parameter bit SIGNED_OUT = 1'b0
) (
   input  logic signed [IN_W-1:0]  din,
   output logic        [OUT_W-1:0] dout
);

   localparam logic signed [IN_W-1:0] HI = SIGNED_OUT
      ? (IN_W'(1) <<< (OUT_W - 1)) - IN_W'(1)
      : (IN_W'(1) <<< OUT_W) - IN_W'(1);
   localparam logic signed [IN_W-1:0] LO = SIGNED_OUT
      ? -(IN_W'(1) <<< (OUT_W - 1))
      : IN_W'(0);

   always_comb begin
      dout = din[OUT_W-1:0];
      if (din > HI) begin
         dout = HI[OUT_W-1:0];
      end else if (din < LO) begin
         dout = LO[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/pid_controller_seq.sv
// PID controller, one shared multiplier sequenced IDLE->MUL_P->MUL_I->MUL_D->SUM->OUT; optional PID_ANTIWINDUP_EN.
// Latency: out_valid is high after the 4th edge following accept (5th cycle counting the accept cycle); one sample per 6 cycles.
// Backpressure: result held in OUT until out_ready; in_ready is high only in IDLE.
module pid_controller_seq
   import pid_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int FRAC_W = 4,
   parameter int ACC_W  = DATA_W + COEF_W + 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] setpoint,
   input  logic [DATA_W-1:0] feedback,
   input  logic [COEF_W-1:0] kp,
   input  logic [COEF_W-1:0] ki,
   input  logic [COEF_W-1:0] kd,
   input  logic              clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] control_signal,
   output logic              sat_flag
);

   localparam int ERR_W  = err_w(DATA_W);
   localparam int DIFF_W = diff_w(DATA_W);
   localparam int SUM_W  = sum_w(ACC_W);
   localparam int GAIN_W = COEF_W + 1;
   localparam int PROD_W = GAIN_W + DIFF_W;

   state_t state, state_nxt;

   logic signed [ERR_W-1:0]  e_r, e_prev;
   logic        [COEF_W-1:0] kp_r, ki_r, kd_r;
   logic signed [PROD_W-1:0] p_r, ti_r, d_r;
   logic signed [ACC_W-1:0]  acc;

   logic signed [GAIN_W-1:0] mul_a;
   logic signed [DIFF_W-1:0] mul_b;
   logic signed [PROD_W-1:0] mul_p;
   logic signed [DIFF_W-1:0] e_diff;

   logic signed [ACC_W:0]    acc_sum;
   logic signed [ACC_W-1:0]  acc_n, acc_nxt;
   logic signed [SUM_W-1:0]  s, y;
   logic        [DATA_W-1:0] ctrl_c;
   logic                     sat_c;

   // FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid) state_nxt = MUL_P;
         end
         MUL_P: state_nxt = MUL_I;
         MUL_I: state_nxt = MUL_D;
         MUL_D: state_nxt = SUM;
         SUM:   state_nxt = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Single shared multiplier; gains are unsigned, so zero-extend into the signed operand.
   assign e_diff = DIFF_W'(e_r) - DIFF_W'(e_prev);

   always_comb begin
      mul_a = $signed({1'b0, kd_r});
      mul_b = e_diff;
      case (state)
         MUL_P: begin
            mul_a = $signed({1'b0, kp_r});
            mul_b = DIFF_W'(e_r);
         end
         MUL_I: begin
            mul_a = $signed({1'b0, ki_r});
            mul_b = DIFF_W'(e_r);
         end
         default: ;
      endcase
   end

   assign mul_p = PROD_W'(mul_a) * PROD_W'(mul_b);

   // Integrator update, clamped to the signed ACC_W range so it can never wrap.
   assign acc_sum = (ACC_W + 1)'(acc) + (ACC_W + 1)'(ti_r);

   pid_sat #(
      .IN_W       (ACC_W + 1),
      .OUT_W      (ACC_W),
      .SIGNED_OUT (1'b1)
   ) u_acc_sat (
      .din  (acc_sum),
      .dout (acc_n)
   );

`ifdef PID_ANTIWINDUP_EN
   logic sat_hi, sat_lo, hold;

   // Freeze integration that would push further into the last clamp direction.
   assign hold    = (sat_hi && !ti_r[PROD_W-1] && (ti_r != '0)) || (sat_lo && ti_r[PROD_W-1]);
   assign acc_nxt = hold ? acc : acc_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_hi <= 1'b0;
         sat_lo <= 1'b0;
      end else if (state == SUM) begin
         sat_hi <= sat_c && !y[SUM_W-1];
         sat_lo <= y[SUM_W-1];
      end
   end
`else
   assign acc_nxt = acc_n;
`endif

   assign s = SUM_W'(p_r) + SUM_W'(acc_nxt) + SUM_W'(d_r);
   assign y = s >>> FRAC_W;

   pid_sat #(
      .IN_W       (SUM_W),
      .OUT_W      (DATA_W),
      .SIGNED_OUT (1'b0)
   ) u_out_sat (
      .din  (y),
      .dout (ctrl_c)
   );

   assign sat_c = (y != $signed({{(SUM_W - DATA_W){1'b0}}, ctrl_c}));

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_r            <= '0;
         e_prev         <= '0;
         kp_r           <= '0;
         ki_r           <= '0;
         kd_r           <= '0;
         p_r            <= '0;
         ti_r           <= '0;
         d_r            <= '0;
         acc            <= '0;
         control_signal <= '0;
         sat_flag       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  e_r  <= $signed({1'b0, setpoint}) - $signed({1'b0, feedback});
                  kp_r <= kp;
                  ki_r <= ki;
                  kd_r <= kd;
               end
            end
            MUL_P: p_r  <= mul_p;
            MUL_I: ti_r <= mul_p;
            MUL_D: d_r  <= mul_p;
            SUM: begin
               acc            <= acc_nxt;
               e_prev         <= e_r;
               control_signal <= ctrl_c;
               sat_flag       <= sat_c;
            end
            default: ;
         endcase
         // clear overrides any state update; the SUM output above still used acc_nxt
         if (clear) begin
            acc    <= '0;
            e_prev <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pid_controller_seq.sv
// Scoreboard bench for pid_controller_seq: driver queues expected results, a negedge monitor checks them.
module tb_pid_controller_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] setpoint, feedback, kp, ki, kd;
   logic       clear;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] control_signal;
   logic       sat_flag;

   typedef struct {
      logic [7:0] ctrl;
      logic       sat;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   int   acc_edge = 0;
   logic ov_prev = 1'b0;

   pid_controller_seq #(
      .DATA_W (8),
      .COEF_W (8),
      .FRAC_W (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .setpoint       (setpoint),
      .feedback       (feedback),
      .kp             (kp),
      .ki             (ki),
      .kd             (kd),
      .clear          (clear),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .control_signal (control_signal),
      .sat_flag       (sat_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: latency on out_valid rise, result compare on each output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (in_valid && in_ready) acc_edge = cyc + 1;
      if (out_valid && !ov_prev) chk("latency", cyc - acc_edge, 4);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("control_signal", int'(control_signal), int'(e.ctrl));
            chk("sat_flag", int'(sat_flag), int'(e.sat));
         end
      end
      ov_prev = out_valid;
   end

   task automatic issue(input logic [7:0] sp, input logic [7:0] fb,
                        input logic [7:0] gp, input logic [7:0] gi, input logic [7:0] gd);
      int n = 0;
      setpoint = sp;
      feedback = fb;
      kp       = gp;
      ki       = gi;
      kd       = gd;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("tx_done", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic run(input logic [7:0] sp, input logic [7:0] fb,
                      input logic [7:0] gp, input logic [7:0] gi, input logic [7:0] gd,
                      input logic [7:0] ec, input logic es);
      exp_t e;
      e.ctrl = ec;
      e.sat  = es;
      exp_q.push_back(e);
      issue(sp, fb, gp, gi, gd);
      drain();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      exp_t e;
      rst       = 1'b1;
      in_valid  = 1'b0;
      setpoint  = '0;
      feedback  = '0;
      kp        = '0;
      ki        = '0;
      kd        = '0;
      clear     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_control", control_signal, 0);
      chk("reset_sat", sat_flag, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_in_ready", in_ready, 1);

      // Proportional and output clamps
      run(100, 60, 16, 0, 0, 40, 1'b0);
      run(10, 50, 16, 0, 0, 0, 1'b1);
      run(200, 0, 64, 0, 0, 255, 1'b1);

      // Integral accumulation, then clear
      for (int i = 1; i <= 5; i++) run(53, 50, 0, 16, 0, 8'(3 * i), 1'b0);
      pulse_clear();
      run(53, 50, 0, 16, 0, 3, 1'b0);

      // Derivative, then reset wipes e_prev
      pulse_clear();
      run(60, 50, 0, 0, 16, 10, 1'b0);
      run(80, 50, 0, 0, 16, 20, 1'b0);
      pulse_reset();
      run(80, 50, 0, 0, 16, 30, 1'b0);

      // Output backpressure: result must hold while out_ready is low
      out_ready = 1'b0;
      e.ctrl = 8'd40;
      e.sat  = 1'b0;
      exp_q.push_back(e);
      issue(100, 60, 16, 0, 0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_control", control_signal, 40);
         chk("bp_sat", sat_flag, 0);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      drain();

      // Reset during MUL_I discards the sample and the integrator
      run(53, 50, 0, 16, 0, 3, 1'b0);
      issue(53, 50, 0, 16, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_control", control_signal, 0);
      chk("midrst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run(53, 50, 0, 16, 0, 3, 1'b0);

`ifndef PID_ANTIWINDUP_EN
      // Integrator windup: output stays pinned after the error reverses
      pulse_clear();
      run(150, 50, 0, 16, 0, 100, 1'b0);
      run(150, 50, 0, 16, 0, 200, 1'b0);
      run(150, 50, 0, 16, 0, 255, 1'b1);
      run(150, 50, 0, 16, 0, 255, 1'b1);
      run(150, 50, 0, 16, 0, 255, 1'b1);
      run(30, 50, 0, 16, 0, 255, 1'b1);
      run(30, 50, 0, 16, 0, 255, 1'b1);
`endif

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
